seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Monitors the multiplexed anode/cathode outputs of the seven-segment scan driver and rebuilds the displayed 8-digit frame as 4-bit digit codes.
- Acts as the decoder for the segment encoder/scan path. Used for on-chip score readback (tennis point display) and as a self-check that the displayed value matches what was intended.
- Sits beside the scan driver in the same clock domain, on the same clk.

Parameters:
- N_DIG, 8, number of multiplexed digits (anode width).
- SETTLE_CYC, 4, consecutive identical cycles of (anode, segment) required before a digit is captured.
- TIMEOUT_CYC, 1048576, cycles allowed to complete a frame before it is declared stale.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- an_n  in  N_DIG  anode enables, active-low, expected one-hot-low.
- seg_n  in  7  cathodes, active-low, bit6=g … bit0=a.
- digits  out  4*N_DIG  decoded frame; digit i occupies bits [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when digits is updated.
- bad_pattern  out  1  high for the frame just published if any digit decoded as 4'hF.
- multi_an_err  out  1  sticky, set when more than one anode is low.
- stale  out  1  set on timeout, cleared on the next frame_valid.

Behaviour:
- Reset is rst, synchronous, active-high.
- Reset values:
  - digits = all 4'hA (blank).
  - frame_valid, bad_pattern, multi_an_err and stale = 0.
  - seen mask, settle counter and timeout counter = 0.
- Internal segment vector: seg = ~seg_n.
- Decode table lives in the package; it must match the encoder exactly:
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4.
  - 1101101→5, 1111100→6, 0100111→7, 1111111→8, 1100111→9.
  - 0000000→4'hA (blank).
  - Any other pattern → 4'hF (invalid).
- Anode classification each cycle:
  - all high → BLANK_SLOT.
  - exactly one low → slot index k.
  - more than one low → MULTI: set multi_an_err; no capture; settle counter cleared.
- States:
  - IDLE: wait for a one-hot anode → load settle counter = 1, latch (an_n, seg_n) → SETTLE.
  - SETTLE:
    - If (an_n, seg_n) equals the latch, increment the counter.
    - When counter reaches SETTLE_CYC, write the decoded code to slot k of the shadow frame and set seen[k] → HOLD.
    - On any change → IDLE. The same cycle is re-evaluated as an IDLE entry.
  - HOLD: remain until (an_n, seg_n) changes → IDLE. This gives exactly one capture per dwell.
- A slot captured twice in one frame is overwritten by the later value. The seen bit stays set.
- Frame publish:
  - The cycle after seen becomes all-ones: digits ← shadow, bad_pattern ← OR of (shadow==F), frame_valid=1 for one cycle, seen ← 0, timeout counter ← 0, stale ← 0.
  - Total latency from the dwell start of the last digit to frame_valid = SETTLE_CYC+1 cycles.
- Timeout:
  - The timeout counter increments every cycle while seen≠0 or no frame has been published since reset.
  - At TIMEOUT_CYC: stale ← 1, seen ← 0, counter ← 0. digits keeps its last published value.
- multi_an_err clears only on rst.
- rst mid-dwell or mid-frame discards the shadow frame and returns to IDLE. frame_valid never fires in the reset cycle.
- Segment glitch inside a dwell (one-cycle change) restarts the settle, so ghosting on anode transitions is never captured.

Decomposition:
- Package seg_pkg holds:
  - The ten digit encodings plus BLANK_SEG.
  - Codes CODE_BLANK=4'hA and CODE_BAD=4'hF.
  - Function seg_to_code.
  - Localparam state encodings (IDLE/SETTLE/HOLD).
- One sub-module: seg_dwell_detect. It contains the anode classifier, settle counter and state machine, and outputs capture_stb, slot index, code and multi flag.
- The top holds the shadow frame, seen mask, publish logic and timeout.

Test Plan:
- Scan 8 slots, 16 cycles each, segments {0,0,4,5,3,1,1,0} in slot order 7..0 → one frame_valid pulse; digits = {0,0,4,5,3,1,1,0} per slot; bad_pattern=0.
- Same scan with 2 blank cycles (an_n=FF) between slots and 1-cycle wrong-segment ghost at each slot start → identical digits; no 4'hF.
- Slot 3 driven with 0001000 for 16 cycles → frame published, digit3=F, bad_pattern=1, others correct.
- an_n=8'b11110011 for 1 cycle mid-scan → multi_an_err=1 and stays 1 across later frames until rst; frame still completes from the remaining valid dwells.
- Dwell of exactly SETTLE_CYC-1 cycles on slot 5, no retry → no frame_valid. After TIMEOUT_CYC (bench override 1000) → stale=1, digits unchanged. The next full scan → frame_valid, stale=0.
- Assert rst for 1 cycle after 6 of 8 slots captured, then scan remaining 2 slots only → no frame_valid. A full scan afterward → frame_valid.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment encodings,
// digit codes, dwell FSM states and the segment-to-code lookup.
package seg_pkg;

  // Active-high segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0100111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] BLANK_SEG = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } dwell_state_t;

  function automatic logic [3:0] seg_to_code(input logic [6:0] seg);
    case (seg)
      SEG_0:     return 4'd0;
      SEG_1:     return 4'd1;
      SEG_2:     return 4'd2;
      SEG_3:     return 4'd3;
      SEG_4:     return 4'd4;
      SEG_5:     return 4'd5;
      SEG_6:     return 4'd6;
      SEG_7:     return 4'd7;
      SEG_8:     return 4'd8;
      SEG_9:     return 4'd9;
      BLANK_SEG: return CODE_BLANK;
      default:   return CODE_BAD;
    endcase
  endfunction

endpackage

// File: rtl/seg_dwell_detect.sv
// Classifies the anode bus and emits one capture strobe per stable dwell
// of SETTLE_CYC identical (anode, segment) cycles on a single digit.
module seg_dwell_detect
  import seg_pkg::*;
#(
  parameter int N_DIG      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_DIG-1:0]           an_n,
  input  logic [6:0]                 seg_n,
  output logic                       capture_stb,
  output logic [$clog2(N_DIG)-1:0]   slot,
  output logic [3:0]                 code,
  output logic                       multi
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  logic [N_DIG-1:0]         an;
  logic                     is_multi;
  logic                     one_hot;
  logic                     same;
  logic                     hit;
  logic [$clog2(N_DIG)-1:0] slot_idx;
  logic [N_DIG-1:0]         lat_an_n;
  logic [6:0]               lat_seg_n;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;
  dwell_state_t             state;

  assign an       = ~an_n;
  assign is_multi = (an & (an - N_DIG'(1))) != '0;
  assign one_hot  = (an != '0) && !is_multi;
  assign same     = (state != IDLE) && (an_n == lat_an_n) && (seg_n == lat_seg_n);

  always_comb begin
    slot_idx = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (an[i]) slot_idx = ($clog2(N_DIG))'(i);
    end
  end

  // A change while settling or holding is treated as a fresh IDLE entry in
  // the same cycle, so back-to-back digits lose no dwell cycles.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    cnt_next = '0;
    if (same)         cnt_next = (state == SETTLE) ? cnt + CNT_W'(1) : cnt;
    else if (one_hot) cnt_next = CNT_W'(1);
    hit = one_hot && !(same && state == HOLD) && (cnt_next == CNT_W'(SETTLE_CYC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_an_n    <= '1;
      lat_seg_n   <= '1;
      capture_stb <= 1'b0;
      slot        <= '0;
      code        <= CODE_BLANK;
      multi       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      cnt         <= cnt_next;
      capture_stb <= hit;
      multi       <= is_multi;
      if (!same) begin
        lat_an_n  <= an_n;
        lat_seg_n <= seg_n;
      end
      if (hit) begin
        slot <= slot_idx;
        code <= seg_to_code(~seg_n);
      end
      if (hit || (same && state == HOLD)) state <= HOLD;
      else if (same || one_hot)           state <= SETTLE;
      else                                state <= IDLE;
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the multiplexed display frame from the scan driver outputs,
// publishing complete frames and flagging stale or malformed scans.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int N_DIG       = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_DIG-1:0]     an_n,
  input  logic [6:0]           seg_n,
  output logic [4*N_DIG-1:0]   digits,
  output logic                 frame_valid,
  output logic                 bad_pattern,
  output logic                 multi_an_err,
  output logic                 stale
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic                     capture_stb;
  logic                     multi;
  logic [$clog2(N_DIG)-1:0] slot;
  logic [3:0]               code;
  logic [4*N_DIG-1:0]       shadow;
  logic [N_DIG-1:0]         seen;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     published;
  logic                     shadow_bad;
  logic                     counting;

  seg_dwell_detect #(
    .N_DIG      (N_DIG),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_dwell (
    .clk         (clk),
    .rst         (rst),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .capture_stb (capture_stb),
    .slot        (slot),
    .code        (code),
    .multi       (multi)
  );

  always_comb begin
    shadow_bad = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (shadow[4*i +: 4] == CODE_BAD) shadow_bad = 1'b1;
    end
  end

  // Timeout only runs while a frame is partly built, or before the first one.
  assign counting = (seen != '0) || !published;

  always_ff @(posedge clk) begin
    if (rst) begin
      digits       <= {N_DIG{CODE_BLANK}};
      // NOTE: the shadow frame is reset so a half-built frame never leaks out.
      shadow       <= {N_DIG{CODE_BLANK}};
      seen         <= '0;
      frame_valid  <= 1'b0;
      bad_pattern  <= 1'b0;
      multi_an_err <= 1'b0;
      stale        <= 1'b0;
      tmo_cnt      <= '0;
      published    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (multi) multi_an_err <= 1'b1;

      if (&seen) begin
        digits      <= shadow;
        bad_pattern <= shadow_bad;
        frame_valid <= 1'b1;
        seen        <= '0;
        tmo_cnt     <= '0;
        stale       <= 1'b0;
        published   <= 1'b1;
      end else if (counting) begin
        if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          stale   <= 1'b1;
          seen    <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end

      // Later assignment wins, so a capture landing on a clear is kept.
      if (capture_stb) begin
        shadow[4*slot +: 4] <= code;
        seen[slot]          <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench: directed scans plus random dwells, compared every
// cycle against a behavioural model of the frame rebuild rules.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 1000;
  localparam int DWELL  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic [31:0] digits;
  logic        frame_valid, bad_pattern, multi_an_err, stale;

  seg_scan_decoder #(
    .N_DIG       (8),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .an_n         (an_n),
    .seg_n        (seg_n),
    .digits       (digits),
    .frame_valid  (frame_valid),
    .bad_pattern  (bad_pattern),
    .multi_an_err (multi_an_err),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int fv_count = 0;
  int fv_last  = 0;

  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111100, 7'b0100111,
                               7'b1111111, 7'b1100111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_decode(input logic [6:0] seg);
    for (int d = 0; d < 10; d++) if (seg == seg_tbl[d]) return 4'(d);
    if (seg == 7'b0) return 4'hA;
    return 4'hF;
  endfunction

  // Active-low cathodes for a code; A is blank, anything above 9 is the bad pattern
  function automatic logic [6:0] seg_n_of(input logic [3:0] c);
    if (c <= 4'd9) return ~seg_tbl[c];
    if (c == 4'hA) return 7'h7F;
    return ~7'b0001000;
  endfunction

  function automatic logic [7:0] slot_an(input int k);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    return a;
  endfunction

  // Behavioural model: a digit is captured once its one-hot input has been
  // stable for SETTLE cycles; the capture lands one cycle later and a full
  // frame publishes on the cycle after that.
  logic [3:0]  m_shadow [8];
  logic [7:0]  m_seen;
  int          m_tmo, run, cap_slot;
  bit          m_pub, cap_pend, multi_pend;
  logic [7:0]  prev_an;
  logic [6:0]  prev_seg;
  logic [3:0]  cap_code;
  logic [31:0] exp_digits;
  logic        exp_fv, exp_bad, exp_multi, exp_stale;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_shadow[i] = 4'hA;
      m_seen = '0; m_tmo = 0; m_pub = 0; run = 0;
      prev_an = 8'hFF; prev_seg = 7'h7F;
      cap_pend = 0; multi_pend = 0; cap_slot = 0; cap_code = 4'hA;
      exp_digits = 32'hAAAA_AAAA;
      exp_fv = 0; exp_bad = 0; exp_multi = 0; exp_stale = 0;
    end else begin
      exp_fv = 0;
      if (m_seen == 8'hFF) begin
        exp_bad = 0;
        for (int i = 0; i < 8; i++) begin
          exp_digits[4*i +: 4] = m_shadow[i];
          if (m_shadow[i] == 4'hF) exp_bad = 1;
        end
        exp_fv = 1; m_seen = '0; m_tmo = 0; exp_stale = 0; m_pub = 1;
      end else if (m_seen != 0 || !m_pub) begin
        m_tmo++;
        if (m_tmo == TMO) begin
          exp_stale = 1; m_seen = '0; m_tmo = 0;
        end
      end
      if (cap_pend) begin
        m_shadow[cap_slot] = cap_code;
        m_seen[cap_slot]   = 1'b1;
        cap_pend = 0;
      end
      if (multi_pend) exp_multi = 1;
      multi_pend = $countones(~an_n) > 1;
      if ($countones(~an_n) == 1)
        run = (an_n == prev_an && seg_n == prev_seg) ? run + 1 : 1;
      else
        run = 0;
      prev_an = an_n; prev_seg = seg_n;
      if (run == SETTLE) begin
        cap_pend = 1;
        cap_code = model_decode(~seg_n);
        for (int i = 0; i < 8; i++) if (!an_n[i]) cap_slot = i;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("digits", digits, exp_digits);
      check("frame_valid", frame_valid, exp_fv);
      check("bad_pattern", bad_pattern, exp_bad);
      check("multi_an_err", multi_an_err, exp_multi);
      check("stale", stale, exp_stale);
      if (frame_valid === 1'b1) begin
        fv_count++;
        fv_last = cyc;
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      an_n  = a;
      seg_n = s;
    end
  endtask

  task automatic scan(input logic [31:0] f, input int gap, input bit ghost,
                      input int hi, input int lo);
    logic [3:0] c;
    for (int k = hi; k >= lo; k--) begin
      c = f[4*k +: 4];
      if (ghost) drive(slot_an(k), seg_n_of(c) ^ 7'h01, 1);
      drive(slot_an(k), seg_n_of(c), DWELL);
      if (gap > 0) drive(8'hFF, 7'h7F, gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, r, k, len, cv;
    logic [6:0] s;
    rst = 1'b1; an_n = 8'hFF; seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    check("reset_digits", digits, 32'hAAAA_AAAA);
    check("reset_fv", frame_valid, 0);
    check("reset_multi", multi_an_err, 0);
    check("reset_stale", stale, 0);
    rst = 1'b0;

    // Plain scan, last digit timed for publish latency
    base = fv_count;
    scan(32'h0045_3110, 0, 0, 7, 1);
    @(negedge clk);
    an_n = slot_an(0); seg_n = seg_n_of(4'h0);
    t0 = cyc + 1;
    drive(slot_an(0), seg_n_of(4'h0), DWELL - 1);
    drive(8'hFF, 7'h7F, 2);
    check("scan1_frames", fv_count - base, 1);
    check("scan1_digits", digits, 32'h0045_3110);
    check("scan1_model", exp_digits, 32'h0045_3110);
    check("scan1_bad", bad_pattern, 0);
    check("scan1_latency", fv_last - t0, SETTLE + 1);

    // Blank gaps and ghost segments at each slot start
    base = fv_count;
    scan(32'h0045_3110, 2, 1, 7, 0);
    check("ghost_frames", fv_count - base, 1);
    check("ghost_digits", digits, 32'h0045_3110);
    check("ghost_bad", bad_pattern, 0);

    // Undecodable pattern on slot 3
    base = fv_count;
    scan(32'h0045_F110, 0, 0, 7, 0);
    check("bad_frames", fv_count - base, 1);
    check("bad_digits", digits, 32'h0045_F110);
    check("bad_flag", bad_pattern, 1);

    // Two anodes low for one cycle mid-scan
    base = fv_count;
    scan(32'h0045_3110, 0, 0, 7, 4);
    drive(8'b1111_0011, seg_n_of(4'h8), 1);
    scan(32'h0045_3110, 0, 0, 3, 0);
    drive(8'hFF, 7'h7F, 2);
    check("multi_frames", fv_count - base, 1);
    check("multi_set", multi_an_err, 1);
    check("multi_digits", digits, 32'h0045_3110);

    // Short dwell on slot 5 leaves the frame incomplete until timeout
    base = fv_count;
    scan(32'h0045_3110, 0, 0, 7, 6);
    drive(slot_an(5), seg_n_of(4'h4), SETTLE - 1);
    drive(8'hFF, 7'h7F, TMO + 50);
    check("stale_frames", fv_count - base, 0);
    check("stale_set", stale, 1);
    check("stale_digits", digits, 32'h0045_3110);
    base = fv_count;
    scan(32'h9876_5432, 0, 0, 7, 0);
    drive(8'hFF, 7'h7F, 2);
    check("recover_frames", fv_count - base, 1);
    check("recover_stale", stale, 0);
    check("recover_digits", digits, 32'h9876_5432);
    check("multi_sticky", multi_an_err, 1);

    // Random dwells, blanks, multi-anode blips and arbitrary segments
    repeat (250) begin
      r   = $urandom_range(0, 19);
      k   = $urandom_range(0, 7);
      len = $urandom_range(1, 8);
      cv  = $urandom_range(0, 11);
      s   = (cv == 11) ? 7'($urandom) : seg_n_of(4'(cv));
      if (r == 0)      drive(8'($urandom) & slot_an(k), s, 1);
      else if (r < 3)  drive(8'hFF, 7'h7F, len);
      else             drive(slot_an(k), s, len);
    end
    drive(8'hFF, 7'h7F, TMO + 100);

    // Reset part way through a frame discards it
    scan(32'h1234_5678, 0, 0, 7, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = fv_count;
    scan(32'h1234_5678, 0, 0, 1, 0);
    drive(8'hFF, 7'h7F, 4);
    check("rst_frames", fv_count - base, 0);
    check("rst_digits", digits, 32'hAAAA_AAAA);
    check("rst_multi", multi_an_err, 0);
    base = fv_count;
    scan(32'h1234_5678, 0, 0, 7, 0);
    drive(8'hFF, 7'h7F, 2);
    check("post_rst_frames", fv_count - base, 1);
    check("post_rst_digits", digits, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
